receipt_chain_arbiter: RTL and testbench

Shares one `crypto_receipt_controller` hash engine between `NUM_REQ` requesters (partition cores / CPU contexts) and owns the global receipt hash chain. Round-robin grant, drives the engine's start and chain inputs, steers the engine's state-input mux via `eng_sel`, captures each result, and advances the chain head H_t on chained requests. Accumulates total hash μ-cost and bounds each engine operation with a timeout watchdog.

---
 rtl/receipt_chain_arbiter.sv | 170 +++++++++++++++++
 tb/tb_receipt_chain_arbiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/receipt_chain_arbiter.sv
// Round-robin arbiter sharing one receipt hash engine between NUM_REQ requesters.
// Owns the global receipt chain head, chain length and accumulated hash mu-cost.
module receipt_chain_arbiter #(
    parameter int unsigned NUM_REQ        = 4,
    parameter int unsigned SEL_W          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req_valid,
    input  logic [NUM_REQ-1:0] req_chain,
    output logic [NUM_REQ-1:0] req_ready,
    output logic [NUM_REQ-1:0] resp_valid,
    output logic [255:0]       resp_hash,
    output logic               resp_error,
    input  logic               chain_clear,
    output logic               eng_compute_hash,
    output logic               eng_use_chain,
    output logic [255:0]       eng_prev_hash,
    output logic [SEL_W-1:0]   eng_sel,
    input  logic               eng_busy,
    input  logic               eng_hash_ready,
    input  logic [255:0]       eng_curr_hash,
    input  logic [31:0]        eng_mu_cost,
    output logic [255:0]       chain_head,
    output logic [31:0]        chain_len,
    output logic [63:0]        mu_total,
    output logic               busy
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESPOND} state_t;

    state_t             r_state;
    logic [SEL_W-1:0]   r_last_grant;
    logic [SEL_W-1:0]   r_sel;
    logic               r_use_chain;
    logic [NUM_REQ-1:0] r_req_ready;
    logic [NUM_REQ-1:0] r_resp_valid;
    logic [255:0]       r_resp_hash;
    logic               r_resp_error;
    logic               r_compute;
    logic [255:0]       r_chain_head;
    logic [31:0]        r_chain_len;
    logic [63:0]        r_mu_total;
    logic               r_busy;
    logic [CNT_W-1:0]   r_cnt;

    logic [SEL_W-1:0]   w_base;
    logic [SEL_W-1:0]   w_cand;
    logic [SEL_W-1:0]   w_grant_idx;
    logic               w_grant_any;
    logic [64:0]        w_mu_sum;

    // In RESPOND the current grant already counts as the last one, so the
    // next accept can land the cycle right after the response pulse.
    always_comb begin
        w_base      = (r_state == S_RESPOND) ? r_sel : r_last_grant;
        w_cand      = '0;
        w_grant_idx = '0;
        w_grant_any = 1'b0;
        for (int i = int'(NUM_REQ); i >= 1; i--) begin
            w_cand = SEL_W'((32'(w_base) + 32'(i)) % NUM_REQ);
            if (req_valid[w_cand]) begin
                w_grant_idx = w_cand;
                w_grant_any = 1'b1;
            end
        end
    end

    assign w_mu_sum = {1'b0, r_mu_total} + 65'(eng_mu_cost);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= S_IDLE;
            r_last_grant <= SEL_W'(NUM_REQ - 1);
            r_sel        <= '0;
            r_use_chain  <= 1'b0;
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_resp_hash  <= '0;
            r_resp_error <= 1'b0;
            r_compute    <= 1'b0;
            r_chain_head <= '0;
            r_chain_len  <= '0;
            r_mu_total   <= '0;
            r_busy       <= 1'b0;
            r_cnt        <= '0;
        end else begin
            r_req_ready  <= '0;
            r_resp_valid <= '0;
            r_compute    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (chain_clear) begin
                        r_chain_head <= '0;
                        r_chain_len  <= '0;
                    end else if (w_grant_any) begin
                        r_req_ready <= NUM_REQ'(1) << w_grant_idx;
                        r_sel       <= w_grant_idx;
                        r_use_chain <= req_chain[w_grant_idx];
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (!eng_busy) begin
                        r_compute <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    if (eng_hash_ready) begin
                        r_resp_hash  <= eng_curr_hash;
                        r_resp_error <= 1'b0;
                        r_resp_valid <= NUM_REQ'(1) << r_sel;
                        if (r_use_chain) begin
                            r_chain_head <= eng_curr_hash;
                            if (r_chain_len != '1) begin
                                r_chain_len <= r_chain_len + 32'd1;
                            end
                        end
                        r_mu_total <= w_mu_sum[64] ? '1 : w_mu_sum[63:0];
                        r_state    <= S_RESPOND;
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_resp_hash  <= '0;
                        r_resp_error <= 1'b1;
                        r_resp_valid <= NUM_REQ'(1) << r_sel;
                        r_state      <= S_RESPOND;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_RESPOND: begin
                    r_last_grant <= r_sel;
                    // A pending clear gets IDLE first so it cannot be starved.
                    if (!chain_clear && w_grant_any) begin
                        r_req_ready <= NUM_REQ'(1) << w_grant_idx;
                        r_sel       <= w_grant_idx;
                        r_use_chain <= req_chain[w_grant_idx];
                        r_state     <= S_ISSUE;
                    end else begin
                        r_busy  <= 1'b0;
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign req_ready        = r_req_ready;
    assign resp_valid       = r_resp_valid;
    assign resp_hash        = r_resp_hash;
    assign resp_error       = r_resp_error;
    assign eng_compute_hash = r_compute;
    assign eng_use_chain    = r_use_chain;
    assign eng_sel          = r_sel;
    assign chain_head       = r_chain_head;
    assign eng_prev_hash    = r_chain_head;
    assign chain_len        = r_chain_len;
    assign mu_total         = r_mu_total;
    assign busy             = r_busy;

endmodule

// File: tb/tb_receipt_chain_arbiter.sv
// Directed bench for receipt_chain_arbiter: chaining, round-robin, timeout,
// chain clear, mu-cost saturation and reset during an engine operation.
module tb_receipt_chain_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_chain;
    logic [3:0]   req_ready;
    logic [3:0]   resp_valid;
    logic [255:0] resp_hash;
    logic         resp_error;
    logic         chain_clear;
    logic         eng_compute_hash;
    logic         eng_use_chain;
    logic [255:0] eng_prev_hash;
    logic [1:0]   eng_sel;
    logic         eng_busy;
    logic         eng_hash_ready;
    logic [255:0] eng_curr_hash;
    logic [31:0]  eng_mu_cost;
    logic [255:0] chain_head;
    logic [31:0]  chain_len;
    logic [63:0]  mu_total;
    logic         busy;

    int checks = 0;
    int errors = 0;
    int waited;
    logic seen;

    localparam logic [255:0] H_AA = {32{8'hAA}};
    localparam logic [255:0] H_55 = {32{8'h55}};
    localparam logic [255:0] H_CC = {32{8'hCC}};
    localparam logic [255:0] H_FF = {32{8'hFF}};
    localparam logic [255:0] H_77 = {32{8'h77}};
    localparam logic [255:0] H_99 = {32{8'h99}};

    receipt_chain_arbiter #(
        .NUM_REQ(4), .SEL_W(2), .TIMEOUT_CYCLES(16)
    ) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_chain(req_chain), .req_ready(req_ready),
        .resp_valid(resp_valid), .resp_hash(resp_hash), .resp_error(resp_error),
        .chain_clear(chain_clear),
        .eng_compute_hash(eng_compute_hash), .eng_use_chain(eng_use_chain),
        .eng_prev_hash(eng_prev_hash), .eng_sel(eng_sel),
        .eng_busy(eng_busy), .eng_hash_ready(eng_hash_ready),
        .eng_curr_hash(eng_curr_hash), .eng_mu_cost(eng_mu_cost),
        .chain_head(chain_head), .chain_len(chain_len),
        .mu_total(mu_total), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for an accept pulse and check who got it.
    task automatic grant_check(input int g, output int w);
        w = 0;
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (|req_ready) begin
                w = k;
                break;
            end
        end
        chk($sformatf("grant%0d_ready", g), 256'(req_ready), 256'(4'b0001 << g));
        chk($sformatf("grant%0d_sel", g), 256'(eng_sel), 256'(g));
    endtask

    // Engine stand-in: start pulse seen, result returned lat cycles later.
    task automatic engine_respond(input logic [255:0] h, input logic [31:0] cost,
                                  input int lat, input int g);
        tick();
        chk("compute_start", 256'(eng_compute_hash), 256'(1));
        chk("busy_in_wait", 256'(busy), 256'(1));
        tick();
        chk("compute_pulse_end", 256'(eng_compute_hash), 256'(0));
        repeat (lat - 2) tick();
        eng_hash_ready = 1'b1;
        eng_curr_hash  = h;
        eng_mu_cost    = cost;
        tick();
        eng_hash_ready = 1'b0;
        chk($sformatf("resp%0d_valid", g), 256'(resp_valid), 256'(4'b0001 << g));
        chk("resp_hash", resp_hash, h);
        chk("resp_error", 256'(resp_error), 256'(0));
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_req_ready"}, 256'(req_ready), 256'(0));
        chk({tag, "_resp_valid"}, 256'(resp_valid), 256'(0));
        chk({tag, "_resp_hash"}, resp_hash, 256'(0));
        chk({tag, "_resp_error"}, 256'(resp_error), 256'(0));
        chk({tag, "_compute"}, 256'(eng_compute_hash), 256'(0));
        chk({tag, "_use_chain"}, 256'(eng_use_chain), 256'(0));
        chk({tag, "_sel"}, 256'(eng_sel), 256'(0));
        chk({tag, "_head"}, chain_head, 256'(0));
        chk({tag, "_prev_hash"}, eng_prev_hash, 256'(0));
        chk({tag, "_len"}, 256'(chain_len), 256'(0));
        chk({tag, "_mu"}, 256'(mu_total), 256'(0));
        chk({tag, "_busy"}, 256'(busy), 256'(0));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req_valid = '0; req_chain = '0; chain_clear = 1'b0;
        eng_busy = 1'b0; eng_hash_ready = 1'b0; eng_curr_hash = '0; eng_mu_cost = '0;
        tick(); tick();
        chk_reset_outputs("reset");
        rst = 1'b0;
        tick();

        // Single chained request from requester 0.
        req_valid = 4'b0001; req_chain = 4'b0001;
        grant_check(0, waited);
        req_valid = '0;
        chk("t1_use_chain", 256'(eng_use_chain), 256'(1));
        engine_respond(H_AA, 32'd112, 10, 0);
        chk("t1_head", chain_head, H_AA);
        chk("t1_len", 256'(chain_len), 256'(1));
        chk("t1_mu", 256'(mu_total), 256'(112));
        tick();

        // Second chained request sees the new head as prev hash.
        req_valid = 4'b0100; req_chain = 4'b0100;
        grant_check(2, waited);
        req_valid = '0;
        chk("t2_prev_hash", eng_prev_hash, H_AA);
        engine_respond(H_55, 32'd40, 4, 2);
        chk("t2_head", chain_head, H_55);
        chk("t2_len", 256'(chain_len), 256'(2));
        chk("t2_mu", 256'(mu_total), 256'(152));
        tick();

        // Unchained request: head/len untouched, cost still accumulates.
        req_valid = 4'b0010; req_chain = 4'b0000;
        grant_check(1, waited);
        req_valid = '0;
        chk("t3_use_chain", 256'(eng_use_chain), 256'(0));
        engine_respond(256'h1234, 32'd8, 3, 1);
        chk("t3_head", chain_head, H_55);
        chk("t3_len", 256'(chain_len), 256'(2));
        chk("t3_mu", 256'(mu_total), 256'(160));
        tick();

        // Timeout: engine never answers.
        req_valid = 4'b0001; req_chain = 4'b0001;
        grant_check(0, waited);
        req_valid = '0;
        tick();
        chk("to_compute", 256'(eng_compute_hash), 256'(1));
        repeat (15) tick();
        chk("to_not_early", 256'(resp_valid), 256'(0));
        tick();
        chk("to_resp_valid", 256'(resp_valid), 256'(4'b0001));
        chk("to_resp_error", 256'(resp_error), 256'(1));
        chk("to_resp_hash", resp_hash, 256'(0));
        chk("to_head", chain_head, H_55);
        chk("to_len", 256'(chain_len), 256'(2));
        chk("to_mu", 256'(mu_total), 256'(160));
        tick();
        eng_hash_ready = 1'b1; eng_curr_hash = H_FF; eng_mu_cost = 32'd999;
        tick();
        eng_hash_ready = 1'b0;
        chk("stray_resp_valid", 256'(resp_valid), 256'(0));
        chk("stray_head", chain_head, H_55);
        chk("stray_len", 256'(chain_len), 256'(2));
        chk("stray_mu", 256'(mu_total), 256'(160));
        chk("stray_resp_hash", resp_hash, 256'(0));

        // ISSUE stalls while the engine is frozen.
        eng_busy = 1'b1;
        req_valid = 4'b0010; req_chain = 4'b0010;
        grant_check(1, waited);
        req_valid = '0;
        repeat (3) begin
            tick();
            chk("stall_no_compute", 256'(eng_compute_hash), 256'(0));
        end
        chk("stall_busy", 256'(busy), 256'(1));
        eng_busy = 1'b0;
        engine_respond(H_CC, 32'd10, 5, 1);
        chk("t5_head", chain_head, H_CC);
        chk("t5_len", 256'(chain_len), 256'(3));
        chk("t5_mu", 256'(mu_total), 256'(170));
        tick();

        // chain_clear with a request in IDLE: clear wins, grant deferred.
        chain_clear = 1'b1;
        req_valid = 4'b0100; req_chain = 4'b0000;
        tick();
        chk("clr_no_ready", 256'(req_ready), 256'(0));
        chk("clr_head", chain_head, 256'(0));
        chk("clr_len", 256'(chain_len), 256'(0));
        chk("clr_prev_hash", eng_prev_hash, 256'(0));
        chain_clear = 1'b0;
        grant_check(2, waited);
        chk("clr_defer_one_cycle", 256'(waited), 256'(1));
        req_valid = '0;
        engine_respond(H_77, 32'd5, 3, 2);
        chk("t6_mu", 256'(mu_total), 256'(175));
        chk("t6_head", chain_head, 256'(0));
        tick();

        // mu_total saturation from a preset near the top.
        force dut.r_mu_total = 64'hFFFF_FFFF_FFFF_FF00;
        tick();
        release dut.r_mu_total;
        req_valid = 4'b1000; req_chain = 4'b1000;
        grant_check(3, waited);
        req_valid = '0;
        engine_respond(H_99, 32'd500, 3, 3);
        chk("sat_mu", 256'(mu_total), 256'(64'hFFFF_FFFF_FFFF_FFFF));
        chk("sat_head", chain_head, H_99);
        chk("sat_len", 256'(chain_len), 256'(1));
        tick();

        // Reset in the middle of WAIT.
        req_valid = 4'b0001; req_chain = 4'b0001;
        grant_check(0, waited);
        req_valid = '0;
        tick();
        chk("rw_compute", 256'(eng_compute_hash), 256'(1));
        tick(); tick();
        rst = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        rst = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            tick();
            seen = seen | (|resp_valid);
        end
        chk("midreset_no_resp", 256'(seen), 256'(0));

        // Round-robin with all four requesters held: 0,1,2,3,0.
        req_valid = 4'b1111; req_chain = 4'b0000;
        for (int n = 0; n < 5; n++) begin
            grant_check(n % 4, waited);
            chk("rr_accept_gap", 256'(waited), 256'(1));
            if (n == 4) req_valid = '0;
            engine_respond(256'(n + 1), 32'd1, 3, n % 4);
        end
        chk("rr_mu", 256'(mu_total), 256'(5));
        chk("rr_len", 256'(chain_len), 256'(0));
        tick();
        chk("rr_idle_busy", 256'(busy), 256'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
